instr_fetch_unit: RTL and testbench

//  Fetch stage feeding the instruction decode/execute stage. Owns the word-addressed PC.

---
 rtl/instr_fetch_unit.sv | 186 ++++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//
// Fetch stage in front of decode/execute. Owns the word-addressed PC, issues
// reads to the synchronous instruction memory (one cycle read latency), and
// buffers returned words in a small FIFO. Decode pulls {inst_data, inst_pc}
// over a valid/ready handshake and may redirect the PC at any time; wrong-path
// words are flushed from the FIFO or killed on return through an epoch tag.
//
// Ports
//   clk             rising-edge clock
//   rst_n           synchronous, active-low reset
//   imem_req        read strobe to instruction memory
//   imem_addr       word address of the read (current PC)
//   imem_rdata      read data, returned the cycle after imem_req
//   redirect_valid  decode requests a new fetch PC (highest priority after reset)
//   redirect_pc     new fetch PC
//   inst_valid      FIFO head holds a valid instruction
//   inst_ready      decode accepts the head this cycle
//   inst_data       instruction word at the FIFO head (0 when not valid)
//   inst_pc         PC of inst_data (0 when not valid)
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter int              PC_W     = 5,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst_data,
  output logic [PC_W-1:0] inst_pc
);

  localparam int DATA_W = 32;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int OCC_W  = CNT_W + 1;
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);

  typedef enum logic {
    ST_RESET = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t state_q;
  state_t state_d;
  logic   rst_n_q;

  // Fetch PC and epoch (control).
  logic [PC_W-1:0]   pc_q;
  logic              epoch_q;

  // Request-to-response stage: vld_p1 is the in-flight flag, i.e. a memory
  // response arrives in the current cycle.
  logic              vld_p1;
  logic              epoch_p1;
  logic [PC_W-1:0]   pc_p1;

  // FIFO.
  logic [DATA_W-1:0] fifo_data [DEPTH];
  logic [PC_W-1:0]   fifo_pc   [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [CNT_W-1:0]  count_q;

  logic [OCC_W-1:0]  occupancy;
  logic              issue;
  logic              push;
  logic              pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  function automatic logic [CNT_W-1:0] count_next(input logic [CNT_W-1:0] c,
                                                  input logic            do_push,
                                                  input logic            do_pop);
    logic [CNT_W-1:0] n;
    n = c;
    if (do_push && !do_pop) n = c + CNT_W'(1);
    if (!do_push && do_pop) n = c - CNT_W'(1);
    return n;
  endfunction

  // ---------------------------------------------------------------------
  // FSM: RESET while rst_n is low, RUN from the first edge with rst_n high.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_RESET;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET: state_d = ST_RUN;
      ST_RUN:   state_d = ST_RUN;
      default:  state_d = ST_RESET;
    endcase
  end

  assign rst_n_q = (state_q == ST_RUN);

  // Words already buffered plus the one returning this cycle; a new read is
  // issued only if it is guaranteed a FIFO slot when it comes back.
  assign occupancy = OCC_W'(count_q) + OCC_W'(vld_p1);

  always_comb begin
    issue = 1'b0;
    if (rst_n && rst_n_q && !redirect_valid && (occupancy < DEPTH_OCC)) issue = 1'b1;
  end

  assign imem_req  = issue;
  assign imem_addr = pc_q;

  assign inst_valid = rst_n && (count_q != '0);
  assign inst_data  = inst_valid ? fifo_data[rd_ptr_q] : '0;
  assign inst_pc    = inst_valid ? fifo_pc[rd_ptr_q]   : '0;

  assign pop = inst_valid && inst_ready;

  // Responses tagged with a stale epoch belong to a redirected path; a
  // redirect in the same cycle flushes everything, including this word.
  assign push = vld_p1 && (epoch_p1 == epoch_q) && !redirect_valid;

  // ---------------------------------------------------------------------
  // Stage p0 -> p1: control state (PC, epoch, in-flight tag, FIFO pointers)
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      epoch_q  <= 1'b0;
      vld_p1   <= 1'b0;
      epoch_p1 <= 1'b0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      vld_p1 <= issue;
      if (issue) begin
        pc_q     <= pc_q + PC_W'(1);
        epoch_p1 <= epoch_q;
      end
      if (redirect_valid) begin
        // A pop in this cycle still completes: decode already owns that word.
        pc_q     <= redirect_pc;
        epoch_q  <= ~epoch_q;
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
        if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
        count_q <= count_next(count_q, push, pop);
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stage p1 -> FIFO: request PC and returned word (data, no reset)
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (issue) pc_p1 <= pc_q;
    if (push) begin
      fifo_data[wr_ptr_q] <= imem_rdata;
      fifo_pc[wr_ptr_q]   <= pc_p1;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    count_q <= DEPTH_CNT);

  a_push_has_room: assert property (@(posedge clk) disable iff (!rst_n)
    (push && !pop) |-> (count_q < DEPTH_CNT));

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [4:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [4:0]  redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [4:0]  inst_pc;

  int n_checks = 0;
  int n_fail   = 0;

  logic [4:0]  q_pc[$];
  logic [31:0] q_data[$];

  instr_fetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_data(inst_data), .inst_pc(inst_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: mem[i] = i*3, one-cycle read latency.
  initial imem_rdata = 32'd0;
  always @(posedge clk) if (imem_req) imem_rdata <= 32'(imem_addr) * 32'd3;

  // Record every accepted handshake mid-cycle.
  always @(negedge clk)
    if (rst_n && inst_valid && inst_ready) begin
      q_pc.push_back(inst_pc);
      q_data.push_back(inst_data);
    end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_words(input int n);
    for (int k = 0; k < 60 && q_pc.size() < n; k++) tick();
    n_checks++;
    if (q_pc.size() < n) begin n_fail++; $display("FAIL wait_words got %0d words exp %0d", q_pc.size(), n); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    repeat (3) tick();
    @(negedge clk);
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %0b exp 0", imem_req); end
    n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b exp 0", inst_valid); end
    n_checks++; if (inst_data !== 32'd0) begin n_fail++; $display("FAIL reset_data got %0h exp 0", inst_data); end
    n_checks++; if (inst_pc !== 5'd0) begin n_fail++; $display("FAIL reset_pc got %0d exp 0", inst_pc); end
  endtask

  task automatic test_stream();
    q_pc.delete(); q_data.delete();
    tick();
    rst_n = 1'b1; inst_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL stream_req_in_reset_state got %0b exp 0", imem_req); end
    tick();  // cycle 0: first request
    @(negedge clk);
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 5'd0) begin n_fail++; $display("FAIL stream_first_req got req=%0b addr=%0d exp req=1 addr=0", imem_req, imem_addr); end
    tick();  // cycle 1
    @(negedge clk);
    n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL stream_valid_c1 got %0b exp 0", inst_valid); end
    tick();  // cycle 2
    @(negedge clk);
    n_checks++; if (inst_valid !== 1'b1 || inst_pc !== 5'd0 || inst_data !== 32'd0) begin n_fail++; $display("FAIL stream_valid_c2 got v=%0b pc=%0d d=%0d exp v=1 pc=0 d=0", inst_valid, inst_pc, inst_data); end
    tick();
    wait_words(6);
    for (int j = 0; j < 6 && j < q_pc.size(); j++) begin
      n_checks++;
      if (q_pc[j] !== 5'(j) || q_data[j] !== 32'(j * 3)) begin n_fail++; $display("FAIL stream_word%0d got pc=%0d d=%0d exp pc=%0d d=%0d", j, q_pc[j], q_data[j], j, j * 3); end
    end
  endtask

  task automatic test_backpressure();
    int n0;
    logic [4:0]  hp;
    logic [31:0] hd;
    inst_ready = 1'b0;         // stall cycle 1
    n0 = q_pc.size();
    repeat (2) tick();         // stall cycle 3
    @(negedge clk);
    hp = inst_pc; hd = inst_data;
    n_checks++; if (inst_valid !== 1'b1 || imem_req !== 1'b0) begin n_fail++; $display("FAIL bp_full got v=%0b req=%0b exp v=1 req=0", inst_valid, imem_req); end
    n_checks++; if (hp !== 5'(n0) || hd !== 32'(n0 * 3)) begin n_fail++; $display("FAIL bp_head got pc=%0d d=%0d exp pc=%0d d=%0d", hp, hd, n0, n0 * 3); end
    for (int c = 4; c <= 5; c++) begin
      tick();
      @(negedge clk);
      n_checks++;
      if (imem_req !== 1'b0 || inst_valid !== 1'b1 || inst_pc !== hp || inst_data !== hd) begin n_fail++; $display("FAIL bp_stable_c%0d got req=%0b v=%0b pc=%0d d=%0d exp req=0 v=1 pc=%0d d=%0d", c, imem_req, inst_valid, inst_pc, inst_data, hp, hd); end
    end
    n_checks++; if (q_pc.size() !== n0) begin n_fail++; $display("FAIL bp_no_pop got %0d words exp %0d", q_pc.size(), n0); end
    tick();
    inst_ready = 1'b1;
    wait_words(n0 + 4);
    for (int j = n0; j < n0 + 4 && j < q_pc.size(); j++) begin
      n_checks++;
      if (q_pc[j] !== 5'(j) || q_data[j] !== 32'(j * 3)) begin n_fail++; $display("FAIL bp_resume%0d got pc=%0d d=%0d exp pc=%0d d=%0d", j, q_pc[j], q_data[j], j, j * 3); end
    end
  endtask

  task automatic test_redirect();
    int nr;
    bit ok;
    repeat (3) tick();
    redirect_valid = 1'b1; redirect_pc = 5'd20;   // cycle R
    @(negedge clk);
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL redir_req_R got %0b exp 0", imem_req); end
    tick();                                         // R+1
    redirect_valid = 1'b0;
    nr = q_pc.size();
    ok = 1'b1;
    for (int j = 0; j < nr; j++) if (q_pc[j] !== 5'(j)) ok = 1'b0;
    n_checks++; if (!ok) begin n_fail++; $display("FAIL redir_pre_seq got non-consecutive pcs over %0d words exp 0..%0d", nr, nr - 1); end
    @(negedge clk);
    n_checks++; if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 5'd20) begin n_fail++; $display("FAIL redir_R1 got v=%0b req=%0b addr=%0d exp v=0 req=1 addr=20", inst_valid, imem_req, imem_addr); end
    tick();                                         // R+2
    @(negedge clk);
    n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL redir_R2 got v=%0b exp 0", inst_valid); end
    tick();                                         // R+3
    @(negedge clk);
    n_checks++; if (inst_valid !== 1'b1 || inst_pc !== 5'd20 || inst_data !== 32'd60) begin n_fail++; $display("FAIL redir_R3 got v=%0b pc=%0d d=%0d exp v=1 pc=20 d=60", inst_valid, inst_pc, inst_data); end
    tick();
    wait_words(nr + 3);
    for (int j = 0; j < 3 && nr + j < q_pc.size(); j++) begin
      n_checks++;
      if (q_pc[nr + j] !== 5'(20 + j) || q_data[nr + j] !== 32'((20 + j) * 3)) begin n_fail++; $display("FAIL redir_word%0d got pc=%0d d=%0d exp pc=%0d d=%0d", j, q_pc[nr + j], q_data[nr + j], 20 + j, (20 + j) * 3); end
    end
  endtask

  task automatic test_redirect_pop();
    inst_ready = 1'b0;
    q_pc.delete(); q_data.delete();
    redirect_valid = 1'b1; redirect_pc = 5'd7;
    tick();
    redirect_valid = 1'b0;
    repeat (5) tick();
    @(negedge clk);
    n_checks++; if (inst_valid !== 1'b1 || inst_pc !== 5'd7 || inst_data !== 32'd21) begin n_fail++; $display("FAIL rpop_head got v=%0b pc=%0d d=%0d exp v=1 pc=7 d=21", inst_valid, inst_pc, inst_data); end
    tick();                                         // cycle R: pop 7 + redirect to 2
    inst_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 5'd2;
    tick();                                         // R+1
    redirect_valid = 1'b0;
    n_checks++; if (q_pc.size() !== 1 || q_pc[0] !== 5'd7) begin n_fail++; $display("FAIL rpop_consumed got %0d words exp 1 word pc=7", q_pc.size()); end
    @(negedge clk);
    n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL rpop_R1 got v=%0b exp 0", inst_valid); end
    tick();                                         // R+2
    @(negedge clk);
    n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL rpop_R2 got v=%0b exp 0", inst_valid); end
    tick();                                         // R+3
    @(negedge clk);
    n_checks++; if (inst_valid !== 1'b1 || inst_pc !== 5'd2 || inst_data !== 32'd6) begin n_fail++; $display("FAIL rpop_R3 got v=%0b pc=%0d d=%0d exp v=1 pc=2 d=6", inst_valid, inst_pc, inst_data); end
    tick();
    wait_words(3);
    if (q_pc.size() >= 3) begin
      n_checks++; if (q_pc[1] !== 5'd2 || q_pc[2] !== 5'd3) begin n_fail++; $display("FAIL rpop_seq got %0d,%0d exp 2,3", q_pc[1], q_pc[2]); end
    end
  endtask

  task automatic test_wrap();
    logic [4:0]  exp_pc [4];
    logic [31:0] exp_d  [4];
    exp_pc = '{5'd30, 5'd31, 5'd0, 5'd1};
    exp_d  = '{32'd90, 32'd93, 32'd0, 32'd3};
    inst_ready = 1'b0;
    q_pc.delete(); q_data.delete();
    redirect_valid = 1'b1; redirect_pc = 5'd30;
    tick();
    redirect_valid = 1'b0; inst_ready = 1'b1;
    wait_words(4);
    for (int j = 0; j < 4 && j < q_pc.size(); j++) begin
      n_checks++;
      if (q_pc[j] !== exp_pc[j] || q_data[j] !== exp_d[j]) begin n_fail++; $display("FAIL wrap_word%0d got pc=%0d d=%0d exp pc=%0d d=%0d", j, q_pc[j], q_data[j], exp_pc[j], exp_d[j]); end
    end
  endtask

  task automatic test_reset_mid();
    inst_ready = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    n_checks++; if (inst_valid !== 1'b1 || imem_req !== 1'b0) begin n_fail++; $display("FAIL rmid_full got v=%0b req=%0b exp v=1 req=0", inst_valid, imem_req); end
    tick();                                         // P: one pop frees a slot
    inst_ready = 1'b1;
    tick();                                         // P+1: refill request
    inst_ready = 1'b0;
    @(negedge clk);
    n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL rmid_refill_req got %0b exp 1", imem_req); end
    tick();                                         // P+2: FIFO full, response returning
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++; if (imem_req !== 1'b0 || inst_valid !== 1'b0 || inst_data !== 32'd0 || inst_pc !== 5'd0) begin n_fail++; $display("FAIL rmid_in_reset got req=%0b v=%0b d=%0d pc=%0d exp all 0", imem_req, inst_valid, inst_data, inst_pc); end
    tick();
    @(negedge clk);
    n_checks++; if (inst_valid !== 1'b0 || imem_req !== 1'b0) begin n_fail++; $display("FAIL rmid_held got v=%0b req=%0b exp 0 0", inst_valid, imem_req); end
    tick();
    q_pc.delete(); q_data.delete();
    inst_ready = 1'b1; rst_n = 1'b1;
    wait_words(3);
    for (int j = 0; j < 3 && j < q_pc.size(); j++) begin
      n_checks++;
      if (q_pc[j] !== 5'(j) || q_data[j] !== 32'(j * 3)) begin n_fail++; $display("FAIL rmid_word%0d got pc=%0d d=%0d exp pc=%0d d=%0d", j, q_pc[j], q_data[j], j, j * 3); end
    end
  endtask

  initial begin
    rst_n = 1'b0; inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_redirect_pop();
    test_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
